// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor result checker and its benches.
package addsub_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Golden add/subtract at the default width; returns {C, V, S}.
  function automatic logic [WIDTH_DEF+1:0] addsub_golden(
    input logic [WIDTH_DEF-1:0] a,
    input logic [WIDTH_DEF-1:0] b,
    input logic                 m
  );
    logic [WIDTH_DEF-1:0] b_eff;
    logic [WIDTH_DEF:0]   sum;
    logic [WIDTH_DEF-1:0] low;
    b_eff = m ? ~b : b;
    sum   = (WIDTH_DEF+1)'(a) + (WIDTH_DEF+1)'(b_eff) + (WIDTH_DEF+1)'(m);
    low   = WIDTH_DEF'(a[WIDTH_DEF-2:0]) + WIDTH_DEF'(b_eff[WIDTH_DEF-2:0]) + WIDTH_DEF'(m);
    return {sum[WIDTH_DEF], low[WIDTH_DEF-1] ^ sum[WIDTH_DEF], sum[WIDTH_DEF-1:0]};
  endfunction

endpackage

// File: rtl/addsub_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // Clear has priority over increment; increment stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/addsub_result_checker.sv
// Response checker for the 4-bit adder/subtractor: golden compare, pass/fail
// counts and first-mismatch capture, one-cycle latency.
module addsub_result_checker
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic             inp_M,
  input  logic [WIDTH-1:0] dut_S,
  input  logic             dut_C,
  input  logic             dut_V,
  input  logic             clear,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_A,
  output logic [WIDTH-1:0] err_B,
  output logic             err_M,
  output logic [WIDTH-1:0] err_exp_S,
  output logic             err_exp_C,
  output logic             err_exp_V
);

  localparam int unsigned W1 = WIDTH + 1;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             m_q, c_q, v_q;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] low_c;
  logic [WIDTH-1:0] exp_s_c;
  logic             exp_c_c, exp_v_c;
  logic             mismatch_c, accept_c, pub_c, halt_c;

  // Golden result of the registered transaction, full WIDTH+1 precision.
  always_comb begin
    b_eff_c    = m_q ? ~b_q : b_q;
    sum_c      = W1'(a_q) + W1'(b_eff_c) + W1'(m_q);
    low_c      = WIDTH'(a_q[WIDTH-2:0]) + WIDTH'(b_eff_c[WIDTH-2:0]) + WIDTH'(m_q);
    exp_s_c    = sum_c[WIDTH-1:0];
    exp_c_c    = sum_c[WIDTH];
    exp_v_c    = low_c[WIDTH-1] ^ sum_c[WIDTH];
    mismatch_c = (exp_s_c != s_q) || (exp_c_c != c_q) || (exp_v_c != v_q);
  end

  // Handshake and publish qualifiers; clear suppresses both.
  always_comb begin
    accept_c = in_valid && in_ready && !clear;
    pub_c    = (state == CHECK) && !clear;
    halt_c   = pub_c && mismatch_c && HALT_ON_ERR;
  end

  // FSM, input capture, publish strobe and first-error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      err_flag  <= 1'b0;
      err_A     <= '0;
      err_B     <= '0;
      err_M     <= 1'b0;
      err_exp_S <= '0;
      err_exp_C <= 1'b0;
      err_exp_V <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      err_flag  <= 1'b0;
      err_A     <= '0;
      err_B     <= '0;
      err_M     <= 1'b0;
      err_exp_S <= '0;
      err_exp_C <= 1'b0;
      err_exp_V <= 1'b0;
    end else begin
      chk_valid <= pub_c;
      chk_pass  <= pub_c && !mismatch_c;
      if (pub_c && mismatch_c) begin
        err_flag <= 1'b1;
        if (!err_flag) begin
          err_A     <= a_q;
          err_B     <= b_q;
          err_M     <= m_q;
          err_exp_S <= exp_s_c;
          err_exp_C <= exp_c_c;
          err_exp_V <= exp_v_c;
        end
      end
      if (halt_c || (state == HALT)) begin
        state    <= HALT;
        in_ready <= 1'b0;
      end else if (accept_c) begin
        state    <= CHECK;
        in_ready <= 1'b1;
        a_q      <= inp_A;
        b_q      <= inp_B;
        m_q      <= inp_M;
        s_q      <= dut_S;
        c_q      <= dut_C;
        v_q      <= dut_V;
      end else begin
        state    <= IDLE;
        in_ready <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (pub_c && !mismatch_c),
    .q   (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (pub_c && mismatch_c),
    .q   (fail_cnt)
  );

endmodule

// File: tb/tb_addsub_result_checker.sv
// Directed bench: halting checker (defaults) and a non-halting 2-bit-counter variant.
module tb_addsub_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       valid0, valid1;
  logic [3:0] a, b, s;
  logic       m, c, v;

  logic       rdy0, cv0, cp0, ef0, em0, ec0, evv0;
  logic [7:0] pc0, fc0;
  logic [3:0] ea0, eb0, es0;

  logic       rdy1, cv1, cp1, ef1, em1, ec1, evv1;
  logic [1:0] pc1, fc1;
  logic [3:0] ea1, eb1, es1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_result_checker #(.WIDTH(4), .CNT_W(8), .HALT_ON_ERR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(valid0), .in_ready(rdy0),
    .inp_A(a), .inp_B(b), .inp_M(m), .dut_S(s), .dut_C(c), .dut_V(v),
    .clear(clear), .chk_valid(cv0), .chk_pass(cp0), .pass_cnt(pc0), .fail_cnt(fc0),
    .err_flag(ef0), .err_A(ea0), .err_B(eb0), .err_M(em0),
    .err_exp_S(es0), .err_exp_C(ec0), .err_exp_V(evv0)
  );

  addsub_result_checker #(.WIDTH(4), .CNT_W(2), .HALT_ON_ERR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(valid1), .in_ready(rdy1),
    .inp_A(a), .inp_B(b), .inp_M(m), .dut_S(s), .dut_C(c), .dut_V(v),
    .clear(clear), .chk_valid(cv1), .chk_pass(cp1), .pass_cnt(pc1), .fail_cnt(fc1),
    .err_flag(ef1), .err_A(ea1), .err_B(eb1), .err_M(em1),
    .err_exp_S(es1), .err_exp_C(ec1), .err_exp_V(evv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [3:0] ta, input logic [3:0] tb, input logic tm,
                     input logic [3:0] ts, input logic tc, input logic tv);
    a = ta; b = tb; m = tm; s = ts; c = tc; v = tv;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    vec(4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    #12;
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_valid", 32'(cv0), 32'd0);
    check("rst_cnts", 32'({pc0, fc0, ef0}), 32'd0);
    rst = 1'b0;
    #2;
    check("ready_low_before_edge", 32'(rdy0), 32'd0);
    step();
    check("ready_after_rst", 32'(rdy0), 32'd1);

    // Back-to-back adds, all correct
    valid0 = 1'b1;
    vec(4'b1100, 4'b1011, 1'b0, 4'b0111, 1'b1, 1'b1); step();
    vec(4'b0101, 4'b1001, 1'b0, 4'b1110, 1'b0, 1'b0); step();
    check("add1_valid", 32'({cv0, cp0}), 32'b11);
    vec(4'b1010, 4'b0001, 1'b0, 4'b1011, 1'b0, 1'b0); step();
    check("add2_valid", 32'({cv0, cp0}), 32'b11);
    valid0 = 1'b0; step();
    check("add3_valid", 32'({cv0, cp0}), 32'b11);
    step();
    check("add_idle_valid", 32'(cv0), 32'd0);
    check("add_pass_cnt", 32'(pc0), 32'd3);
    check("add_fail_cnt", 32'(fc0), 32'd0);

    // Subtract vectors
    do_clear();
    valid0 = 1'b1;
    vec(4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0); step();
    vec(4'b1010, 4'b0110, 1'b1, 4'b0100, 1'b1, 1'b1); step();
    valid0 = 1'b0; step(); step();
    check("sub_pass_cnt", 32'(pc0), 32'd2);
    check("sub_fail_cnt", 32'(fc0), 32'd0);
    check("sub_err_flag", 32'(ef0), 32'd0);

    // Injected error with halt; the valid held into the compare edge is dropped
    do_clear();
    valid0 = 1'b1;
    vec(4'b0101, 4'b1001, 1'b0, 4'b1111, 1'b0, 1'b0); step();
    vec(4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0); step();
    check("err_publish", 32'({cv0, cp0}), 32'b10);
    check("err_fail_cnt", 32'(fc0), 32'd1);
    check("err_flag", 32'(ef0), 32'd1);
    check("err_exp_S", 32'(es0), 32'b1110);
    check("err_A", 32'(ea0), 32'b0101);
    check("err_B", 32'(eb0), 32'b1001);
    check("err_exp_CV", 32'({ec0, evv0, em0}), 32'b000);
    check("halt_ready", 32'(rdy0), 32'd0);
    step(); step();
    check("halt_no_publish", 32'(cv0), 32'd0);
    check("halt_counts", 32'({pc0, fc0}), 32'({8'd0, 8'd1}));
    valid0 = 1'b0;
    do_clear();
    check("clear_counts", 32'({pc0, fc0}), 32'd0);
    check("clear_err", 32'({ef0, ea0, es0}), 32'd0);
    check("clear_ready", 32'(rdy0), 32'd1);

    // Non-halting: two mismatches then one pass; first mismatch retained
    valid1 = 1'b1;
    vec(4'b1100, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b1); step();
    vec(4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0); step();
    check("nh_ready", 32'(rdy1), 32'd1);
    vec(4'b1010, 4'b0001, 1'b0, 4'b1011, 1'b0, 1'b0); step();
    valid1 = 1'b0; step(); step();
    check("nh_fail_cnt", 32'(fc1), 32'd2);
    check("nh_pass_cnt", 32'(pc1), 32'd1);
    check("nh_err_ops", 32'({ea1, eb1, em1}), 32'({4'b1100, 4'b1011, 1'b0}));
    check("nh_err_exp", 32'({es1, ec1, evv1}), 32'({4'b0111, 1'b1, 1'b1}));

    // Saturation at 2 bits after five passes
    do_clear();
    valid1 = 1'b1;
    vec(4'b0101, 4'b1001, 1'b0, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    valid1 = 1'b0; step(); step();
    check("sat_pass_cnt", 32'(pc1), 32'b11);
    check("sat_fail_cnt", 32'(fc1), 32'd0);

    // Async reset between accept and compare edges
    valid0 = 1'b1; step();          // accept A
    valid0 = 1'b0; step();          // publish A
    check("pre_rst_pass", 32'(pc0), 32'd1);
    valid0 = 1'b1; step();          // accept B, in flight
    valid0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rdy0), 32'd0);
    check("mid_rst_counts", 32'({pc0, fc0}), 32'd0);
    @(posedge clk); #2;
    check("mid_rst_no_valid", 32'(cv0), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready_low", 32'(rdy0), 32'd0);
    step();
    check("post_rst_ready", 32'(rdy0), 32'd1);
    check("post_rst_no_valid", 32'(cv0), 32'd0);
    check("post_rst_counts", 32'({pc0, fc0}), 32'd0);

    // Clear coincident with accept discards the transaction
    valid0 = 1'b1; clear = 1'b1; step();
    valid0 = 1'b0; clear = 1'b0; step();
    check("clr_acc_valid", 32'(cv0), 32'd0);
    step();
    check("clr_acc_counts", 32'({pc0, fc0}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
